// File: rtl/cmd_fifo_pkg.sv
// ---------------------------------------------------------------------------
// cmd_fifo_pkg
// Definitions shared by the command FIFO producer and the consumer's decoder:
//   - default command byte values for the S and O keys
//   - key bit positions within key_sig
//   - producer FSM state encoding (2 bits)
// ---------------------------------------------------------------------------
package cmd_fifo_pkg;

  // Command bytes; the consumer decoder must use the same values.
  localparam logic [7:0] CODE_S_DEF = 8'h1B;
  localparam logic [7:0] CODE_O_DEF = 8'h44;

  // Bit positions inside key_sig.
  localparam int KEY_S = 1;
  localparam int KEY_O = 0;

  // Producer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_fifo_write_module_rise_edge_detect.sv
// ---------------------------------------------------------------------------
// rise_edge_detect
// Per-bit rising-edge detector. Keeps a one-cycle history of each input bit
// and flags a bit that is high now but was low at the previous clock edge.
// A level held high therefore yields exactly one flag.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset (clears history)
//   sig_i   in   WIDTH input levels, synchronous to clk
//   rise_o  out  WIDTH rising-edge flags, valid in the cycle the edge is seen
// ---------------------------------------------------------------------------
module rise_edge_detect #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= sig_i;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign rise_o[gi] = sig_i[gi] & ~prev_q[gi];
    end
  endgenerate

endmodule

// File: rtl/cmd_fifo_write_module.sv
// ---------------------------------------------------------------------------
// cmd_fifo_write_module
// Producer end of the command FIFO. Key rising edges become command bytes
// (S -> CODE_S, O -> CODE_O) written into the FIFO with a one-cycle strobe.
// Each key has a one-deep pending latch; overflowing events and commands that
// time out against a full FIFO are counted in a saturating drop counter.
// Ports:
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   key_sig[1:0]     in   key levels, [1]=S, [0]=O (debounced, synchronous)
//   full_sig         in   FIFO full flag
//   write_req_sig    out  FIFO write strobe, one cycle per byte
//   fifo_write_data  out  byte presented to the FIFO (holds between writes)
//   busy_sig         out  pending or in-flight command (registered, lags 1)
//   drop_cnt         out  saturating count of dropped commands
// ---------------------------------------------------------------------------
module cmd_fifo_write_module
  import cmd_fifo_pkg::*;
#(
  parameter logic [7:0]  CODE_S    = CODE_S_DEF,
  parameter logic [7:0]  CODE_O    = CODE_O_DEF,
  parameter int unsigned FULL_WAIT = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       key_sig,
  input  logic             full_sig,
  output logic             write_req_sig,
  output logic [7:0]       fifo_write_data,
  output logic             busy_sig,
  output logic [CNT_W-1:0] drop_cnt
);

  // The wait counter only needs to reach FULL_WAIT-1: the timeout fires on
  // the FULL_WAIT-th full cycle spent in CHECK.
  localparam int unsigned WAIT_W    = (FULL_WAIT > 1) ? $clog2(FULL_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FULL_WAIT - 1);

  state_t            state_q, state_d;
  logic              pend_s_q, pend_s_d;
  logic              pend_o_q, pend_o_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              wreq_q, wreq_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [1:0]        key_rise;
  logic              clr_s, clr_o, timeout;
  logic              drop_s, drop_o;
  logic [1:0]        n_drop;
  logic [CNT_W+1:0]  drop_sum;

  rise_edge_detect #(.WIDTH(2)) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (key_sig),
    .rise_o (key_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_s_q <= 1'b0;
      pend_o_q <= 1'b0;
      wait_q   <= '0;
      wreq_q   <= 1'b0;
      data_q   <= 8'h00;
      busy_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pend_s_q <= pend_s_d;
      pend_o_q <= pend_o_d;
      wait_q   <= wait_d;
      wreq_q   <= wreq_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    wait_d  = wait_q;
    wreq_d  = 1'b0;
    clr_s   = 1'b0;
    clr_o   = 1'b0;
    timeout = 1'b0;

    case (state_q)
      IDLE: begin
        // S has priority over O.
        if (pend_s_q) begin
          data_d  = CODE_S;
          clr_s   = 1'b1;
          state_d = CHECK;
        end else if (pend_o_q) begin
          data_d  = CODE_O;
          clr_o   = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!full_sig) begin
          wreq_d  = 1'b1;
          wait_d  = '0;
          state_d = WRITE;
        end else if (FULL_WAIT != 0) begin
          if (wait_q == WAIT_LAST) begin
            timeout = 1'b1;
            wait_d  = '0;
            state_d = IDLE;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      WRITE:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new event beats a same-cycle clear, so it is neither lost nor counted
    // as a drop; only an event hitting a latch that stays set is dropped.
    pend_s_d = key_rise[KEY_S] | (pend_s_q & ~clr_s);
    pend_o_d = key_rise[KEY_O] | (pend_o_q & ~clr_o);
    drop_s   = key_rise[KEY_S] & pend_s_q & ~clr_s;
    drop_o   = key_rise[KEY_O] & pend_o_q & ~clr_o;

    // Several drop sources may fire together; add them all, then saturate.
    n_drop   = {1'b0, drop_s} + {1'b0, drop_o} + {1'b0, timeout};
    drop_sum = {2'b00, drop_q} + (CNT_W+2)'(n_drop);
    if (drop_sum > {2'b00, {CNT_W{1'b1}}}) drop_d = '1;
    else                                   drop_d = drop_sum[CNT_W-1:0];

    busy_d = pend_s_q | pend_o_q | (state_q != IDLE);
  end

  assign write_req_sig   = wreq_q;
  assign fifo_write_data = data_q;
  assign busy_sig        = busy_q;
  assign drop_cnt        = drop_q;

endmodule
